clkdiv_multi: RTL and testbench
===============================

// Module: clkdiv_multi
// PURPOSE
//  Multi-channel programmable clock divider: ch independent dividers clocked by one input clock.
//  Each channel's ratio can change at runtime; the change takes effect glitchlessly at the next period boundary.
//  A common sync pulse re-aligns the output phase of all channels.
//  Sits at the clock-generation front end, feeding several peripheral clock domains from one source.
// PARAMETERS
//  ch = 4   number of channels (>=1)
//  n  = 8   divider ratio width in bits per channel (>=2)
// PORTS
//  in      input   1      clock input to be divided; all logic on posedge in
//  rst_n   input   1      asynchronous active-low reset
//  div     input   ch*n   packed ratios; channel i = div[i*n +: n]; value <2 disables channel
//  sync    input   1      phase-align request, sampled on posedge in
//  busy    output  ch     per channel: ratio update pending or first period after update
//  out     output  ch     divided clocks, registered
// BEHAVIOUR
//  Reset (rst_n low, async): out=0, busy=0, every seldiv=0, phase p=0, state IDLE.
//   Takes effect immediately, including mid-period.
//  Per-channel registers:
//   - seldiv[n]: active ratio D
//   - p[n]: phase 0..D-1
//   - state: IDLE or SETTLE
//  Period start occurs on a posedge when any of the following holds:
//   - D<2 (disabled), or
//   - p==D-1, or
//   - sync==1
//  At period start:
//   - If div_i != seldiv: seldiv<=div_i and state<=SETTLE.
//   - Else if state==SETTLE: state<=IDLE.
//   - p<=0.
//   - out_i<=1 if the newly selected D>=2, else 0.
//  Otherwise: p<=p+1, out_i<=((p+1) < floor(D/2)).
//   - Out is high for floor(D/2) cycles and low for the rest; odd D gives duty below 50%.
//  Out rising edges coincide with posedge in; period is exactly D input cycles once settled.
//  Disabled channel (D<2):
//   - out_i stays 0.
//   - div is re-checked every cycle; a valid div_i loads at the next posedge and out_i rises on that posedge.
//  busy_i = (div_i != seldiv_i) | (state==SETTLE), combinational from registers and the div input.
//  Ratio change mid-period: current period completes with the old D; the new D applies from the next period start.
//   - No runt pulses are produced.
//  sync:
//   - Every enabled channel restarts at p=0 on that posedge; all active outs rise together.
//   - A sync that truncates a period may shorten one low phase; it never shortens a high phase below one input cycle.
//  sync coinciding with a natural period end or a pending div change: treated as a single period start; div loads.
//  Wrap-around: D up to 2^n-1; p never exceeds D-1; there is no overflow.
//  Channels are fully independent except for the shared sync.
// TESTING
//  1) Reset, then div ch0=4, ch1=3 held
//     -> both outs rise 1 posedge after rst_n release.
//     -> ch0 repeats 1,1,0,0; ch1 repeats 1,0,0.
//     -> busy high for the first period, then 0.
//  2) ch0 running D=4; change div to 6 at p=1
//     -> period finishes with 4 cycles (1,1,0,0).
//     -> next period is 1,1,1,0,0,0.
//     -> busy_0 high from the change through the end of the first 6-cycle period.
//  3) ch0 D=5, ch1 D=7 out of phase; pulse sync 1 cycle
//     -> both outs =1 on that posedge.
//     -> next rising edges occur 5 and 7 cycles later.
//  4) div ch2 set 0 then 1 while running D=4
//     -> current period completes; out_2 then stays 0; busy_2 clears after the load.
//  5) Assert rst_n low mid-high phase of D=8
//     -> all outs drop to 0 without waiting for a clock edge.
//     -> after release, behaviour matches test 1 timing.
//  6) n=8, div=255 plus a sync on the same edge as the natural end
//     -> single period start; 127 high / 128 low; no counter overflow.

Source files
------------

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock divider
// glitchless ratio reload at period boundaries, shared phase sync
module clkdiv_multi #(
  parameter int ch = 4,
  parameter int n  = 8
) (
  input  logic            in,
  input  logic            rst_n,
  input  logic [ch*n-1:0] div,
  input  logic            sync,
  output logic [ch-1:0]   busy,
  output logic [ch-1:0]   out
);

  localparam logic [0:0] idle   = 1'b0;
  localparam logic [0:0] settle = 1'b1;

  for (genvar i = 0; i < ch; i++) begin : g_ch
    logic [n-1:0] seldiv;
    logic [n-1:0] p;
    logic [n-1:0] dnew;
    logic [n-1:0] pinc;
    logic [n-1:0] half;
    logic [0:0]   state;
    logic         o;
    logic         off;
    logic         last;
    logic         start;

    assign dnew  = div[i*n +: n];
    assign off   = seldiv < n'(2);
    assign last  = p == seldiv - n'(1);
    assign start = off | last | sync;
    assign pinc  = p + n'(1);
    assign half  = seldiv >> 1;

    // period counter; new ratio is only adopted at a period start
    always_ff @(posedge in or negedge rst_n) begin
      if (!rst_n) begin
        seldiv <= '0;
        p      <= '0;
        state  <= idle;
        o      <= 1'b0;
      end else if (start) begin
        if (dnew != seldiv) begin
          seldiv <= dnew;
          state  <= settle;
        end else if (state == settle) begin
          state  <= idle;
        end
        p <= '0;
        o <= dnew >= n'(2);
      end else begin
        p <= pinc;
        o <= pinc < half;
      end
    end

    assign out[i]  = o;
    assign busy[i] = (dnew != seldiv) | (state == settle);
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: table vectors, corner sequences and
// randomized run against a period-position reference model
module tb_clkdiv_multi;
  localparam int CH = 4;
  localparam int N  = 8;

  logic            in = 1'b0;
  logic            rst_n = 1'b0;
  logic            sync = 1'b0;
  logic [CH*N-1:0] div = '0;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   out;

  clkdiv_multi #(.ch(CH), .n(N)) dut (
    .in(in), .rst_n(rst_n), .div(div),
    .sync(sync), .busy(busy), .out(out)
  );

  always #5 in = ~in;

  int checks = 0;
  int failures = 0;

  // reference: active ratio, position inside period, first-period flag
  int md[CH];
  int mpos[CH];
  bit mset[CH];

  typedef struct {
    int         d0;
    int         d1;
    logic [1:0] eo;
    logic [1:0] eb;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int dval(int i);
    return int'(div[i*N +: N]);
  endfunction

  task automatic setdiv(int i, int v);
    div[i*N +: N] = N'(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      md[i] = 0;
      mpos[i] = 0;
      mset[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      int d;
      d = dval(i);
      if (md[i] < 2 || mpos[i] == md[i] - 1 || sync) begin
        mset[i] = (d != md[i]);
        md[i] = d;
        mpos[i] = 0;
      end else begin
        mpos[i]++;
      end
    end
  endtask

  function automatic int exp_out(int i);
    return int'(md[i] >= 2 && mpos[i] < md[i] / 2);
  endfunction

  function automatic int exp_busy(int i);
    return int'(dval(i) != md[i] || mset[i]);
  endfunction

  task automatic step();
    @(posedge in);
    model_edge();
    #1;
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model_out%0d", i), int'(out[i]), exp_out(i));
      chk($sformatf("model_busy%0d", i), int'(busy[i]), exp_busy(i));
    end
  endtask

  task automatic run_rows(int lo, int hi);
    for (int r = lo; r <= hi; r++) begin
      setdiv(0, tbl[r].d0);
      setdiv(1, tbl[r].d1);
      step();
      chk($sformatf("row%0d_out", r), int'(out[1:0]), int'(tbl[r].eo));
      chk($sformatf("row%0d_busy", r), int'(busy[1:0]), int'(tbl[r].eb));
    end
  endtask

  initial begin
    int r0;
    int r1;
    int hi;
    int lo;
    logic p0;
    logic p1;

    tbl[0]  = '{4, 3, 2'b11, 2'b11};
    tbl[1]  = '{4, 3, 2'b01, 2'b11};
    tbl[2]  = '{4, 3, 2'b00, 2'b11};
    tbl[3]  = '{4, 3, 2'b10, 2'b01};
    tbl[4]  = '{4, 3, 2'b01, 2'b00};
    tbl[5]  = '{4, 3, 2'b01, 2'b00};
    tbl[6]  = '{4, 3, 2'b10, 2'b00};
    tbl[7]  = '{4, 3, 2'b00, 2'b00};
    tbl[8]  = '{4, 3, 2'b01, 2'b00};
    tbl[9]  = '{4, 3, 2'b11, 2'b00};
    tbl[10] = '{6, 3, 2'b00, 2'b01};
    tbl[11] = '{6, 3, 2'b00, 2'b01};
    tbl[12] = '{6, 3, 2'b11, 2'b01};
    tbl[13] = '{6, 3, 2'b01, 2'b01};
    tbl[14] = '{6, 3, 2'b01, 2'b01};
    tbl[15] = '{6, 3, 2'b10, 2'b01};
    tbl[16] = '{6, 3, 2'b00, 2'b01};
    tbl[17] = '{6, 3, 2'b00, 2'b01};
    tbl[18] = '{6, 3, 2'b11, 2'b00};

    model_reset();
    #12;
    chk("reset_out", int'(out), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge in);
    rst_n = 1'b1;

    // startup with 4/3, then ratio change 4 -> 6 mid-period
    run_rows(0, 18);

    // sync re-alignment of D=5 and D=7
    setdiv(0, 5);
    setdiv(1, 7);
    for (int k = 0; k < 23; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_out_both", int'(out[1:0]), 3);
    r0 = -1;
    r1 = -1;
    p0 = out[0];
    p1 = out[1];
    for (int k = 1; k <= 20; k++) begin
      step();
      if (r0 < 0 && out[0] && !p0) r0 = k;
      if (r1 < 0 && out[1] && !p1) r1 = k;
      p0 = out[0];
      p1 = out[1];
    end
    chk("sync_rise_ch0", r0, 5);
    chk("sync_rise_ch1", r1, 7);

    // disable ch2 via 0 then 1
    setdiv(2, 4);
    for (int k = 0; k < 10; k++) step();
    setdiv(2, 0);
    step();
    setdiv(2, 1);
    for (int k = 0; k < 8; k++) step();
    chk("dis_out2", int'(out[2]), 0);
    chk("dis_busy2", int'(busy[2]), 0);

    // async reset mid-high of D=8
    setdiv(0, 8);
    begin
      int g;
      g = 0;
      while (!(md[0] == 8 && mpos[0] == 1) && g < 40) begin
        step();
        g++;
      end
      chk("rst_reach_high", g < 40 ? 1 : 0, 1);
    end
    chk("rst_pre_out0", int'(out[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", int'(out), 0);
    model_reset();
    div = '0;
    @(negedge in);
    @(negedge in);
    rst_n = 1'b1;
    run_rows(0, 8);

    // D=255 with sync on the natural end
    setdiv(3, 255);
    begin
      int g;
      g = 0;
      while (!(md[3] == 255 && !mset[3] && mpos[3] == 254) && g < 1000) begin
        step();
        g++;
      end
      chk("d255_reach_end", g < 1000 ? 1 : 0, 1);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("d255_start_out", int'(out[3]), 1);
    chk("d255_busy", int'(busy[3]), 0);
    hi = 1;
    lo = 0;
    for (int k = 1; k < 255; k++) begin
      step();
      if (out[3]) hi++;
      else lo++;
    end
    chk("d255_high", hi, 127);
    chk("d255_low", lo, 128);
    step();
    chk("d255_next_rise", int'(out[3]), 1);

    // randomized ratios and syncs
    for (int k = 0; k < 1500; k++) begin
      if ($urandom % 16 == 0)
        setdiv(int'($urandom % CH), int'($urandom_range(0, 12)));
      sync = ($urandom % 30 == 0);
      step();
    end
    sync = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
